hwpe_ctrl_regfile_periph_adapter: RTL and testbench

//  Peripheral-bus target sitting directly upstream of hwpe_ctrl_regfile_latch.

---
 rtl/hwpe_ctrl_regfile_periph_adapter.sv | 119 +++++++++++
 tb/tb_hwpe_ctrl_regfile_periph_adapter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_regfile_periph_adapter.sv
// Peripheral req/gnt target in front of the latch regfile; single response cycle after grant.
// Latency: 1 cycle grant-to-response; bus writes stall behind engine status writes and during clear.
module hwpe_ctrl_regfile_periph_adapter #(
    parameter int ADDR_WIDTH = 5,
    parameter int ID_WIDTH   = 8,
    parameter int RO_REGS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  req,
    output logic                  gnt,
    input  logic [31:0]           add,
    input  logic                  wen,
    input  logic [3:0]            be,
    input  logic [31:0]           data,
    input  logic [ID_WIDTH-1:0]   id,
    output logic                  r_valid,
    output logic [31:0]           r_data,
    output logic                  r_opc,
    output logic [ID_WIDTH-1:0]   r_id,
    input  logic                  status_we,
    output logic                  status_ready,
    input  logic [ADDR_WIDTH-1:0] status_addr,
    input  logic [31:0]           status_data,
    output logic                  rf_read_enable,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [31:0]           rf_read_data,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [31:0]           rf_write_data,
    output logic [3:0]            rf_write_be,
    output logic                  rf_clear
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLR   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RO_LIMIT = RO_REGS[ADDR_WIDTH-1:0];

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rsp_read;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_idle;
    logic                  w_ro;
    logic                  w_status_wr;
    logic                  w_bus_wr;
    logic                  w_unused_add;

    assign w_word       = add[ADDR_WIDTH+1:2];
    assign w_unused_add = ^{add[31:ADDR_WIDTH+2], add[1:0]};
    assign w_idle       = (r_state == IDLE);
    assign w_ro         = (w_word < RO_LIMIT);

    assign status_ready = w_idle & ~clear;
    // A bus read uses the separate read port, so only bus writes yield to status writes.
    assign gnt          = req & status_ready & ~(~wen & status_we);
    assign w_status_wr  = status_we & status_ready;
    assign w_bus_wr     = gnt & ~wen & ~w_ro;

    assign rf_read_enable = gnt & wen;
    assign rf_read_addr   = (gnt & wen) ? w_word : '0;

    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_write_be     = '0;
        if (w_status_wr) begin
            rf_write_enable = 1'b1;
            rf_write_addr   = status_addr;
            rf_write_data   = status_data;
            rf_write_be     = 4'hF;
        end else if (w_bus_wr) begin
            rf_write_enable = 1'b1;
            rf_write_addr   = w_word;
            rf_write_data   = data;
            rf_write_be     = be;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rf_clear    = 1'b0;
        case (r_state)
            IDLE:    if (clear) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = CLR;
            CLR: begin
                rf_clear    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_opc      <= 1'b0;
            r_id       <= '0;
            r_rsp_read <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= gnt;
            r_opc      <= gnt & ~wen & w_ro;
            r_rsp_read <= gnt & wen;
            if (gnt) r_id <= id;
        end
    end

    // Read data comes straight from the regfile output in the response cycle.
    assign r_data = r_rsp_read ? rf_read_data : 32'h0;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_periph_adapter.sv
// Directed bench for hwpe_ctrl_regfile_periph_adapter with a small behavioural regfile behind it.
module tb_hwpe_ctrl_regfile_periph_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  id;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_opc;
    logic [7:0]  r_id;
    logic        status_we;
    logic        status_ready;
    logic [4:0]  status_addr;
    logic [31:0] status_data;
    logic        rf_read_enable;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [3:0]  rf_write_be;
    logic        rf_clear;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hwpe_ctrl_regfile_periph_adapter #(
        .ADDR_WIDTH(5), .ID_WIDTH(8), .RO_REGS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req(req), .gnt(gnt), .add(add), .wen(wen), .be(be), .data(data), .id(id),
        .r_valid(r_valid), .r_data(r_data), .r_opc(r_opc), .r_id(r_id),
        .status_we(status_we), .status_ready(status_ready),
        .status_addr(status_addr), .status_data(status_data),
        .rf_read_enable(rf_read_enable), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_write_be(rf_write_be),
        .rf_clear(rf_clear)
    );

    // Regfile model: write/clear at the edge, read address latched, data presented next cycle.
    logic [31:0] mem [32];
    logic [4:0]  m_raddr;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        m_raddr = '0;
    end

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (rf_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (rf_write_be[b]) mem[rf_write_addr][b*8 +: 8] <= rf_write_data[b*8 +: 8];
        end
        if (rf_read_enable) m_raddr <= rf_read_addr;
    end

    assign rf_read_data = mem[m_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [7:0] i);
        req = r; wen = w; add = a; data = d; be = b; id = i;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; status_we = 1'b0; status_addr = '0; status_data = '0;
        bus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'h0);
        #12;
        chk("rst_r_valid", {31'b0, r_valid}, 32'h0);
        chk("rst_r_data", r_data, 32'h0);
        chk("rst_r_opc", {31'b0, r_opc}, 32'h0);
        chk("rst_r_id", {24'b0, r_id}, 32'h0);
        chk("rst_gnt", {31'b0, gnt}, 32'h0);
        chk("rst_rf_we", {31'b0, rf_write_enable}, 32'h0);
        chk("rst_rf_clear", {31'b0, rf_clear}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: full write to word 5
        bus(1'b1, 1'b0, 32'h14, 32'hDEADBEEF, 4'hF, 8'd3);
        #1;
        chk("t1_gnt", {31'b0, gnt}, 32'h1);
        chk("t1_we", {31'b0, rf_write_enable}, 32'h1);
        chk("t1_waddr", {27'b0, rf_write_addr}, 32'h5);
        chk("t1_wdata", rf_write_data, 32'hDEADBEEF);
        tick();
        chk("t1_r_valid", {31'b0, r_valid}, 32'h1);
        chk("t1_r_id", {24'b0, r_id}, 32'h3);
        chk("t1_r_opc", {31'b0, r_opc}, 32'h0);
        chk("t1_r_data", r_data, 32'h0);

        // 2: partial write then read back
        bus(1'b1, 1'b0, 32'h14, 32'h0000AA00, 4'b0010, 8'd4);
        #1;
        chk("t2_be", {28'b0, rf_write_be}, 32'h2);
        tick();
        bus(1'b1, 1'b1, 32'h14, 32'h0, 4'h0, 8'd5);
        #1;
        chk("t2_rd_en", {31'b0, rf_read_enable}, 32'h1);
        chk("t2_raddr", {27'b0, rf_read_addr}, 32'h5);
        tick();
        chk("t2_r_data", r_data, 32'hDEADAAEF);
        chk("t2_r_id", {24'b0, r_id}, 32'h5);
        bus(1'b1, 1'b1, 32'h80000097, 32'h0, 4'h0, 8'd6);
        #1;
        chk("wrap_raddr", {27'b0, rf_read_addr}, 32'h5);
        tick();
        chk("wrap_r_data", r_data, 32'hDEADAAEF);

        // status write to read-only word 1
        bus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
        status_we = 1'b1; status_addr = 5'd1; status_data = 32'hCAFE0001;
        #1;
        chk("st_ready", {31'b0, status_ready}, 32'h1);
        chk("st_waddr", {27'b0, rf_write_addr}, 32'h1);
        chk("st_be", {28'b0, rf_write_be}, 32'hF);
        tick();
        status_we = 1'b0;
        chk("st_no_rsp", {31'b0, r_valid}, 32'h0);

        // 3: bus write to read-only word is refused
        bus(1'b1, 1'b0, 32'h04, 32'h11111111, 4'hF, 8'd7);
        #1;
        chk("t3_gnt", {31'b0, gnt}, 32'h1);
        chk("t3_we", {31'b0, rf_write_enable}, 32'h0);
        tick();
        chk("t3_r_opc", {31'b0, r_opc}, 32'h1);
        chk("t3_r_id", {24'b0, r_id}, 32'h7);
        bus(1'b1, 1'b1, 32'h04, 32'h0, 4'h0, 8'd8);
        tick();
        chk("t3_rd_data", r_data, 32'hCAFE0001);
        chk("t3_rd_opc", {31'b0, r_opc}, 32'h0);

        // 4: status write stalls a concurrent bus write
        bus(1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 4'hF, 8'd9);
        status_we = 1'b1; status_addr = 5'd2; status_data = 32'h12345678;
        #1;
        chk("t4_gnt0", {31'b0, gnt}, 32'h0);
        chk("t4_waddr", {27'b0, rf_write_addr}, 32'h2);
        chk("t4_wdata", rf_write_data, 32'h12345678);
        tick();
        status_we = 1'b0;
        chk("t4_no_rsp", {31'b0, r_valid}, 32'h0);
        #1;
        chk("t4_gnt1", {31'b0, gnt}, 32'h1);
        chk("t4_waddr8", {27'b0, rf_write_addr}, 32'h8);
        tick();
        chk("t4_r_id", {24'b0, r_id}, 32'h9);
        bus(1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 8'd10);
        tick();
        chk("t4_word2", r_data, 32'h12345678);
        bus(1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 8'd11);
        tick();
        chk("t4_word8", r_data, 32'hA5A5A5A5);

        // read coincident with status write to the same word
        bus(1'b1, 1'b1, 32'h0C, 32'h0, 4'h0, 8'd12);
        status_we = 1'b1; status_addr = 5'd3; status_data = 32'h0BADF00D;
        #1;
        chk("co_gnt", {31'b0, gnt}, 32'h1);
        tick();
        status_we = 1'b0;
        bus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
        chk("co_r_data", r_data, 32'h0BADF00D);

        // 5: clear following a granted read
        bus(1'b1, 1'b1, 32'h14, 32'h0, 4'h0, 8'd13);
        tick();
        chk("t5_rsp_valid", {31'b0, r_valid}, 32'h1);
        chk("t5_rsp_data", r_data, 32'hDEADAAEF);
        clear = 1'b1;
        bus(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 8'd14);
        #1;
        chk("t5_gnt_c0", {31'b0, gnt}, 32'h0);
        chk("t5_sready_c0", {31'b0, status_ready}, 32'h0);
        chk("t5_clr_c0", {31'b0, rf_clear}, 32'h0);
        tick();
        clear = 1'b0;
        #1;
        chk("t5_gnt_c1", {31'b0, gnt}, 32'h0);
        chk("t5_clr_c1", {31'b0, rf_clear}, 32'h0);
        chk("t5_no_rsp", {31'b0, r_valid}, 32'h0);
        tick();
        chk("t5_gnt_c2", {31'b0, gnt}, 32'h0);
        chk("t5_clr_c2", {31'b0, rf_clear}, 32'h1);
        tick();
        bus(1'b1, 1'b1, 32'h14, 32'h0, 4'h0, 8'd15);
        #1;
        chk("t5_gnt_after", {31'b0, gnt}, 32'h1);
        chk("t5_clr_after", {31'b0, rf_clear}, 32'h0);
        tick();
        chk("t5_cleared", r_data, 32'h0);
        chk("t5_r_id", {24'b0, r_id}, 32'hF);

        // 6: asynchronous reset with a response in flight
        bus(1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 8'd16);
        tick();
        bus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
        chk("t6_pre_valid", {31'b0, r_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", {31'b0, r_valid}, 32'h0);
        chk("t6_arst_id", {24'b0, r_id}, 32'h0);
        tick();
        rst_n = 1'b1;
        bus(1'b1, 1'b0, 32'h24, 32'h600DCAFE, 4'hF, 8'd17);
        tick();
        bus(1'b1, 1'b1, 32'h24, 32'h0, 4'h0, 8'd18);
        tick();
        bus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'd0);
        chk("t6_post_valid", {31'b0, r_valid}, 32'h1);
        chk("t6_post_data", r_data, 32'h600DCAFE);
        chk("t6_post_id", {24'b0, r_id}, 32'h12);
        tick();
        chk("t6_idle_valid", {31'b0, r_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
